// File: rtl/prbs_checker.sv
// Receive-side checker for the 32-bit LFSR pattern generator.
// It self-synchronises a local LFSR to the incoming serial stream and declares lock.
// Once locked, it flywheels on its own prediction, so received errors do not corrupt it.
// In the locked state it flags and counts bit errors; excessive errors within a window drop lock.
module prbs_checker #(
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned LOSS_WIN    = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 valid_i,
  input  logic                 data_i,
  input  logic                 clear_i,
  output logic                 lock_o,
  output logic                 bit_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned MatchW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinCntW = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int unsigned WinErrW = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    StHunt,
    StVerify,
    StLocked
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          r_q, r_d;
  logic [4:0]           fill_q, fill_d;
  logic [MatchW-1:0]    match_q, match_d;
  logic [WinCntW-1:0]   win_cnt_q, win_cnt_d;
  logic [WinErrW-1:0]   win_err_q, win_err_d;
  logic                 lock_q, lock_d;
  logic                 bit_err_q, bit_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 pred;
  logic                 mismatch;

  // Next bit the generator would emit from the current local state
  assign pred     = r_q[27] ^ r_q[23] ^ r_q[19] ^ r_q[18] ^ r_q[15] ^
                    r_q[11] ^ r_q[7] ^ r_q[4] ^ r_q[1];
  assign mismatch = data_i ^ pred;

  // Next-state logic: sync search, verification, flywheel tracking and error accounting
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_cnt_d = err_cnt_q;
    bit_err_d = 1'b0;

    if (valid_i) begin
      unique case (state_q)
        StHunt: begin
          r_d    = {r_q[30:0], data_i};
          fill_d = fill_q + 5'd1;
          if (fill_q == 5'd31) begin
            state_d = StVerify;
            match_d = '0;
          end
        end
        StVerify: begin
          // Keep loading received bits so a bad fill resynchronises by itself
          r_d = {r_q[30:0], data_i};
          if (mismatch) begin
            match_d = '0;
          end else begin
            match_d = match_q + MatchW'(1);
            if (match_q == MatchW'(LOCK_CNT - 1)) begin
              if (r_d == '0) begin
                // All-zero is the LFSR lock-up state; never lock onto it
                match_d = '0;
              end else begin
                state_d   = StLocked;
                win_cnt_d = '0;
                win_err_d = '0;
              end
            end
          end
        end
        StLocked: begin
          r_d       = {r_q[30:0], pred};
          bit_err_d = mismatch;
          if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          if (mismatch && (win_err_q == WinErrW'(LOSS_THRESH - 1))) begin
            state_d   = StHunt;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_q == WinCntW'(LOSS_WIN - 1)) begin
            // Window closes on this bit; its error was already judged above
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WinCntW'(1);
            if (mismatch) begin
              win_err_d = win_err_q + WinErrW'(1);
            end
          end
        end
        default: begin
          state_d = StHunt;
          fill_d  = '0;
        end
      endcase
    end

    // Clear takes priority over a same-cycle increment
    if (clear_i) begin
      err_cnt_d = '0;
    end

    lock_d = (state_d == StLocked);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StHunt;
      r_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      lock_q    <= 1'b0;
      bit_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      lock_q    <= lock_d;
      bit_err_q <= bit_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign lock_o    = lock_q;
  assign bit_err_o = bit_err_q;
  assign err_cnt_o = err_cnt_q;

endmodule
